fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 55 +++++
 tb/tb_fetch_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM (clk, rst_f; imem_req/addr/ack/rdata memory port; ir/ir_pc/ir_valid/ir_take issue port; br_taken/br_addr redirect; halt)
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd1
) (
  input  logic        clk,
  input  logic        rst_f,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_take,
  input  logic        br_taken,
  input  logic [15:0] br_addr,
  input  logic        halt
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;
  state_t state, state_n;
  logic [15:0] pc;
  logic load, redirect;
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = halt ? HALT : FETCH;
      FETCH:   state_n = halt ? HALT : br_taken ? FETCH : imem_ack ? HOLD : FETCH;
      HOLD:    state_n = halt ? HALT : (br_taken || ir_take) ? FETCH : HOLD;
      HALT:    state_n = HALT;
      default: state_n = IDLE;
    endcase
  end
  assign redirect  = state != HALT && !halt && br_taken;
  assign load      = state == FETCH && state_n == HOLD;
  assign imem_req  = state == FETCH;
  assign imem_addr = pc;
  assign ir_valid  = state == HOLD;
  always_ff @(posedge clk) begin
    if (rst_f) begin
      state <= IDLE;
      pc    <= RESET_PC;
      ir    <= 32'h0;
      ir_pc <= 16'h0;
    end else begin
      state <= state_n;
      if (redirect) pc <= br_addr;
      else if (load) pc <= pc + PC_STEP;
      if (load) begin
        ir    <= imem_rdata;
        ir_pc <= pc;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table, directed sequences and random run against a reference model
module tb_fetch_unit;
  logic        clk = 0, rst_f = 0, imem_ack = 0, ir_take = 0, br_taken = 0, halt = 0, mem_mode = 1;
  logic [15:0] br_addr = 0, imem_addr, imem_addr2, ir_pc, ir_pc2;
  logic [31:0] imem_rdata, imem_rdata2, ir, ir2, rand_word = 0;
  logic        imem_req, imem_req2, ir_valid, ir_valid2;
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  assign imem_rdata  = mem_mode ? 32'hA000 + {16'h0, imem_addr} : rand_word;
  assign imem_rdata2 = 32'hA000 + {16'h0, imem_addr2};

  fetch_unit dut (
    .clk(clk), .rst_f(rst_f), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_take(ir_take),
    .br_taken(br_taken), .br_addr(br_addr), .halt(halt)
  );

  fetch_unit #(.RESET_PC(16'hFFFF)) dut2 (
    .clk(clk), .rst_f(rst_f), .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata2), .ir(ir2), .ir_pc(ir_pc2), .ir_valid(ir_valid2), .ir_take(ir_take),
    .br_taken(br_taken), .br_addr(br_addr), .halt(halt)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic r, a, t, b, h, input logic [15:0] ba);
    rst_f = r; imem_ack = a; ir_take = t; br_taken = b; halt = h; br_addr = ba;
  endtask

  // Reference model: "started" means IDLE has passed, valid means an instruction is waiting,
  // and a request is outstanding whenever we are started, not halted and not holding.
  logic        m_started, m_halted, m_valid;
  logic [15:0] m_pc, m_ir_pc;
  logic [31:0] m_ir;

  task automatic model_step();
    if (rst_f) begin
      m_started = 0; m_halted = 0; m_valid = 0; m_pc = 16'h0000; m_ir = 0; m_ir_pc = 0;
    end else if (m_halted) begin
    end else if (halt) begin
      m_halted = 1; m_valid = 0;
    end else if (br_taken) begin
      m_pc = br_addr; m_valid = 0; m_started = 1;
    end else if (!m_started) begin
      m_started = 1;
    end else if (m_valid) begin
      if (ir_take) m_valid = 0;
    end else if (imem_ack) begin
      m_ir = rand_word; m_ir_pc = m_pc; m_valid = 1; m_pc = m_pc + 16'd1;
    end
  endtask

  typedef struct {
    logic rst, ack, take, br, hlt;
    logic [15:0] ba;
    logic req, vld;
    logic [15:0] addr, ipc;
    logic [31:0] ir;
  } vec_t;
  vec_t tbl[18];

  initial begin
    tbl[0]  = '{1, 1, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 32'h0};
    tbl[1]  = '{0, 1, 1, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 32'h0};
    tbl[2]  = '{0, 1, 1, 0, 0, 16'h0000, 0, 1, 16'h0000, 16'h0000, 32'hA000};
    tbl[3]  = '{0, 1, 1, 0, 0, 16'h0000, 1, 0, 16'h0001, 16'h0000, 32'hA000};
    tbl[4]  = '{0, 1, 1, 0, 0, 16'h0000, 0, 1, 16'h0000, 16'h0001, 32'hA001};
    tbl[5]  = '{0, 1, 1, 0, 0, 16'h0000, 1, 0, 16'h0002, 16'h0001, 32'hA001};
    tbl[6]  = '{0, 1, 1, 0, 0, 16'h0000, 0, 1, 16'h0000, 16'h0002, 32'hA002};
    tbl[7]  = '{0, 1, 1, 1, 0, 16'h0040, 1, 0, 16'h0040, 16'h0002, 32'hA002};
    tbl[8]  = '{0, 1, 0, 1, 0, 16'h0040, 1, 0, 16'h0040, 16'h0002, 32'hA002};
    tbl[9]  = '{0, 1, 0, 0, 0, 16'h0000, 0, 1, 16'h0000, 16'h0040, 32'hA040};
    tbl[10] = '{0, 1, 0, 0, 1, 16'h0000, 0, 0, 16'h0000, 16'h0040, 32'hA040};
    tbl[11] = '{0, 1, 1, 1, 0, 16'h0010, 0, 0, 16'h0000, 16'h0040, 32'hA040};
    tbl[12] = '{1, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 32'h0};
    tbl[13] = '{0, 1, 1, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 32'h0};
    tbl[14] = '{0, 1, 0, 0, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 32'h0};
    tbl[15] = '{0, 1, 1, 1, 0, 16'h0040, 0, 0, 16'h0000, 16'h0000, 32'h0};
    tbl[16] = '{1, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 32'h0};
    tbl[17] = '{0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 32'h0};

    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rst, tbl[i].ack, tbl[i].take, tbl[i].br, tbl[i].hlt, tbl[i].ba);
      tick();
      chk($sformatf("tbl%0d_req", i), {31'h0, imem_req}, {31'h0, tbl[i].req});
      chk($sformatf("tbl%0d_valid", i), {31'h0, ir_valid}, {31'h0, tbl[i].vld});
      chk($sformatf("tbl%0d_ir", i), ir, tbl[i].ir);
      chk($sformatf("tbl%0d_ir_pc", i), {16'h0, ir_pc}, {16'h0, tbl[i].ipc});
      if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), {16'h0, imem_addr}, {16'h0, tbl[i].addr});
      if (i == 2) chk("wrap_pc0", {16'h0, ir_pc2}, 32'h0000FFFF);
      if (i == 4) chk("wrap_pc1", {16'h0, ir_pc2}, 32'h00000000);
      if (i == 6) chk("wrap_pc2", {16'h0, ir_pc2}, 32'h00000001);
    end

    // delayed ack, long hold, then reset in the middle of a fetch
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("wait%0d_req", i), {31'h0, imem_req}, 32'h1);
      chk($sformatf("wait%0d_addr", i), {16'h0, imem_addr}, 32'h0);
      if (i < 2) tick();
    end
    drive(0, 1, 0, 0, 0, 0); tick();
    chk("ack_ir", ir, 32'hA000);
    chk("ack_valid", {31'h0, ir_valid}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("hold%0d_req", i), {31'h0, imem_req}, 32'h0);
      chk($sformatf("hold%0d_valid", i), {31'h0, ir_valid}, 32'h1);
      chk($sformatf("hold%0d_ir", i), ir, 32'hA000);
    end
    drive(0, 0, 1, 0, 0, 0); tick();
    chk("resume_req", {31'h0, imem_req}, 32'h1);
    chk("resume_addr", {16'h0, imem_addr}, 32'h1);
    drive(1, 1, 0, 0, 0, 0); tick();
    chk("midrst_req", {31'h0, imem_req}, 32'h0);
    chk("midrst_valid", {31'h0, ir_valid}, 32'h0);
    chk("midrst_ir", ir, 32'h0);
    drive(0, 0, 0, 0, 0, 0); tick();
    chk("restart_addr", {16'h0, imem_addr}, 32'h0);
    chk("restart_req", {31'h0, imem_req}, 32'h1);

    // random traffic against the model
    mem_mode = 0;
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk); model_step(); @(negedge clk);
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 5) == 0, $urandom_range(0, 79) == 0, 16'($urandom));
      rand_word = $urandom;
      @(posedge clk); model_step(); @(negedge clk);
      chk("rnd_req", {31'h0, imem_req}, {31'h0, m_started && !m_halted && !m_valid});
      chk("rnd_valid", {31'h0, ir_valid}, {31'h0, m_valid});
      chk("rnd_ir", ir, m_ir);
      chk("rnd_ir_pc", {16'h0, ir_pc}, {16'h0, m_ir_pc});
      if (imem_req) chk("rnd_addr", {16'h0, imem_addr}, {16'h0, m_pc});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
